// File: rtl/mvau_wload_pkg.sv
// Shared types for the MVAU run-time weight loader.
// Loader FSM encoding: no weights, loading, complete weight set held.
package mvau_wload_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        READY = ST_READY
    } wload_state_t;

endpackage

// File: rtl/mvau_wmem_sdp.sv
// Simple-dual-port weight RAM: one write port, one registered read-first read port.
// Read data register resets to 0; array contents are never reset.
// Out-of-range read addresses return 0, out-of-range writes are dropped.
module mvau_wmem_sdp #(
    parameter int unsigned DATA_W  = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_BW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [ADDR_BW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [ADDR_BW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    localparam int unsigned IDX_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BW:0] DEPTH_EXT = (ADDR_BW + 1)'(DEPTH);

    (* ram_style = "auto" *) logic [DATA_W-1:0] mem [DEPTH];

    logic w_in_range;
    logic r_in_range;

    assign w_in_range = ({1'b0, waddr} < DEPTH_EXT);
    assign r_in_range = ({1'b0, raddr} < DEPTH_EXT);

    // Write port; no reset so the array can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            mem[waddr[IDX_BW-1:0]] <= wdata;
        end
    end

    // Registered read; non-blocking semantics give read-first on address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (r_in_range) begin
            rdata <= mem[raddr[IDX_BW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/mvau_weight_mem_loader.sv
// Run-time loader for one MVAU PE weight memory.
// Streams SIMD*TW-bit words into an SDP RAM in address order and exposes the
// same address-in / registered-data-out read port a ROM-based PE uses.
// Optional macro MVAU_WLOAD_TLAST_CHECK_EN enables the sticky tlast framing
// check on load_err; without it tlast is ignored and load_err is tied 0.
module mvau_weight_mem_loader
    import mvau_wload_pkg::*;
#(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    load_start,
    input  logic [SIMD*TW-1:0]      s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic [SIMD*TW-1:0]      wmem_out,
    output logic                    wmem_valid,
    output logic                    load_busy,
    output logic                    load_err
);

    localparam logic [WMEM_ADDR_BW-1:0] LAST_IDX = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    wload_state_t            state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] wcnt_q, wcnt_d;
    logic                    beat;
    logic                    at_last;
    logic                    start_ok;

    // Handshake and status decode purely from state.
    assign s_axis_tready = (state_q == LOAD);
    assign load_busy     = (state_q == LOAD);
    assign wmem_valid    = (state_q == READY);

    assign beat     = s_axis_tvalid && s_axis_tready;
    assign at_last  = (wcnt_q == LAST_IDX);
    assign start_ok = load_start && (state_q != LOAD);

    // Next-state and write-counter logic; load_start during LOAD is ignored.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE, READY: begin
                if (load_start) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (at_last) begin
                        // Hold the counter so it never wraps when DEPTH == 2**ADDR_BW.
                        state_d = READY;
                    end else begin
                        wcnt_d = wcnt_q + WMEM_ADDR_BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef MVAU_WLOAD_TLAST_CHECK_EN
    logic err_q;

    // Sticky framing error: tlast must be high exactly on the final-index beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (beat && (s_axis_tlast != at_last)) begin
            err_q <= 1'b1;
        end
    end

    assign load_err = err_q;
`else
    logic unused_tlast;
    logic unused_start_ok;

    assign unused_tlast    = s_axis_tlast;
    assign unused_start_ok = start_ok;
    assign load_err        = 1'b0;
`endif

    mvau_wmem_sdp #(
        .DATA_W  (SIMD * TW),
        .DEPTH   (WMEM_DEPTH),
        .ADDR_BW (WMEM_ADDR_BW)
    ) u_wmem (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (beat),
        .waddr (wcnt_q),
        .wdata (s_axis_tdata),
        .raddr (wmem_addr),
        .rdata (wmem_out)
    );

endmodule

// File: tb/tb_mvau_weight_mem_loader.sv
// Self-checking bench for mvau_weight_mem_loader (SIMD=2, TW=4, DEPTH=4).
module tb_mvau_weight_mem_loader;

    localparam int unsigned SIMD  = 2;
    localparam int unsigned TW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ABW   = 4;
    localparam int unsigned DW    = SIMD * TW;

`ifdef MVAU_WLOAD_TLAST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic           load_start = 1'b0;
    logic [DW-1:0]  tdata = '0;
    logic           tvalid = 1'b0;
    logic           tlast = 1'b0;
    logic [ABW-1:0] raddr = '0;
    logic           tready;
    logic [DW-1:0]  rdata;
    logic           wvalid;
    logic           busy;
    logic           err;

    mvau_weight_mem_loader #(
        .SIMD         (SIMD),
        .TW           (TW),
        .WMEM_DEPTH   (DEPTH),
        .WMEM_ADDR_BW (ABW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load_start    (load_start),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .wmem_addr     (raddr),
        .wmem_out      (rdata),
        .wmem_valid    (wvalid),
        .load_busy     (busy),
        .load_err      (err)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: loading/ready flags, a beat count, and a word array.
    logic [DW-1:0]  m_mem   [16];
    bit             m_known [16];
    bit             m_loading;
    bit             m_ready;
    bit             m_err;
    logic [ABW-1:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict, drive, clock, compare all outputs against the model.
    task automatic tick(input bit st, input bit v, input logic [DW-1:0] d, input bit l,
                        input logic [ABW-1:0] ra);
        bit            rd_known;
        logic [DW-1:0] rd_exp;
        rd_known = m_known[ra];
        rd_exp   = m_mem[ra];
        if (m_loading) begin
            if (v) begin
                if (CHECK_EN && (l != (m_cnt == ABW'(DEPTH - 1)))) m_err = 1'b1;
                m_mem[m_cnt]   = d;
                m_known[m_cnt] = 1'b1;
                if (m_cnt == ABW'(DEPTH - 1)) begin
                    m_loading = 1'b0;
                    m_ready   = 1'b1;
                end else begin
                    m_cnt = m_cnt + ABW'(1);
                end
            end
        end else if (st) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_err     = 1'b0;
            m_cnt     = '0;
        end
        load_start = st;
        tvalid     = v;
        tdata      = d;
        tlast      = l;
        raddr      = ra;
        @(posedge aclk);
        #1;
        check("tready", 32'(tready), 32'(m_loading));
        check("load_busy", 32'(busy), 32'(m_loading));
        check("wmem_valid", 32'(wvalid), 32'(m_ready));
        check("load_err", 32'(err), 32'(m_err));
        if (rd_known) check("wmem_out", 32'(rdata), 32'(rd_exp));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        aresetn = 1'b0;
        m_loading = 1'b0;
        m_ready   = 1'b0;
        m_err     = 1'b0;
        #1;
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_wmem_valid", 32'(wvalid), 32'd0);
        check("rst_load_busy", 32'(busy), 32'd0);
        check("rst_load_err", 32'(err), 32'd0);
        check("rst_wmem_out", 32'(rdata), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    typedef struct {
        bit             st;
        bit             v;
        logic [DW-1:0]  d;
        bit             l;
        logic [ABW-1:0] ra;
        bit             tr;
        bit             val;
        bit             chk_rd;
        logic [DW-1:0]  rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // Back-to-back load of 0x11..0x44, then read 0..3.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 1'b1, 8'h44, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 8'h33};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 8'h44};

        for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
        m_loading = 1'b0;
        m_ready   = 1'b0;
        m_err     = 1'b0;
        m_cnt     = '0;

        // Reset state, with tvalid high to show tready stays low.
        tvalid = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("reset_tready", 32'(tready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(wvalid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_wmem_out", 32'(rdata), 32'd0);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h5A, 1'b0, 4'd0);

        // Table-driven back-to-back load.
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ra);
            check("tbl_tready", 32'(tready), 32'(tbl[i].tr));
            check("tbl_valid", 32'(wvalid), 32'(tbl[i].val));
            if (tbl[i].chk_rd) check("tbl_rd", 32'(rdata), 32'(tbl[i].rd));
        end

        // tvalid toggling: four beats spread over eight cycles.
        tick(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, (i % 2) == 0, 8'(8'h11 * (i / 2 + 1)), i == 6, 4'd0);
            if (i == 5) check("toggle_not_done", 32'(wvalid), 32'd0);
        end
        check("toggle_done", 32'(wvalid), 32'd1);
        for (int a = 0; a < 4; a++) tick(1'b0, 1'b0, 8'h00, 1'b0, ABW'(a));
        check("toggle_rd3", 32'(rdata), 32'h44);

        // Reload from READY with a read-first collision on address 1.
        tick(1'b1, 1'b0, 8'h00, 1'b0, 4'd1);
        check("reload_valid_drop", 32'(wvalid), 32'd0);
        tick(1'b0, 1'b1, 8'hA0, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 8'hA1, 1'b0, 4'd1);
        check("read_first", 32'(rdata), 32'h22);
        tick(1'b0, 1'b1, 8'hA2, 1'b0, 4'd2);
        tick(1'b0, 1'b1, 8'hA3, 1'b1, 4'd3);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 4'd1);
        check("reload_rd1", 32'(rdata), 32'hA1);

        // tlast on beat 2 of 4.
        tick(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 8'(8'hC0 + i), i == 1, 4'd0);
            if (i == 1) check("tlast_err", 32'(err), 32'(CHECK_EN));
        end
        check("tlast_complete", 32'(wvalid), 32'd1);
        check("tlast_err_sticky", 32'(err), 32'(CHECK_EN));
        tick(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        check("tlast_err_clear", 32'(err), 32'd0);

        // Reset after two beats, then a full load.
        tick(1'b0, 1'b1, 8'hB0, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 8'hB1, 1'b0, 4'd0);
        async_reset();
        tick(1'b0, 1'b1, 8'h77, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'hD0 + i), i == 3, 4'd0);
        check("post_rst_valid", 32'(wvalid), 32'd1);
        for (int a = 0; a < 4; a++) tick(1'b0, 1'b0, 8'h00, 1'b0, ABW'(a));
        check("post_rst_rd3", 32'(rdata), 32'hD3);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, ABW'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
